mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 198 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit: turns byte-addressed load/store requests
// into accesses on a word-addressed, byte-lane RAM with a 1-cycle registered read.
module mem_lsu #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [1:0]          i_req_size,
    input  logic                i_req_unsigned,
    input  logic [ADDR_WIDTH:0] i_req_addr,
    input  logic [DATA_WIDTH:0] i_req_wdata,
    output logic                o_rsp_valid,
    output logic [DATA_WIDTH:0] o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_ram_read_req,
    output logic [ADDR_WIDTH:0] o_ram_read_addr,
    input  logic [DATA_WIDTH:0] i_ram_read_data,
    output logic                o_ram_write_enable,
    output logic [3:0]          o_ram_byte_enable,
    output logic [ADDR_WIDTH:0] o_ram_write_addr,
    output logic [DATA_WIDTH:0] o_ram_write_data
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR       = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [ADDR_WIDTH:0] r_addr;
    logic [DATA_WIDTH:0] r_wdata;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_WIDTH:0] r_rsp_rdata;
    logic                r_ram_read_req;
    logic                r_ram_write_enable;
    logic [3:0]          r_ram_byte_enable;

    logic                w_misaligned;
    logic [3:0]          w_byte_enable;
    logic [7:0]          w_lane_byte;
    logic [15:0]         w_lane_half;
    logic [DATA_WIDTH:0] w_load_data;
    logic [DATA_WIDTH:0] w_store_data;

    // Alignment and lane decode look at the live request so the first state
    // transition can already skip the RAM on a bad request.
    always_comb begin
        w_misaligned = 1'b0;
        case (i_req_size)
            SZ_BYTE: w_misaligned = 1'b0;
            SZ_HALF: w_misaligned = i_req_addr[0];
            SZ_WORD: w_misaligned = |i_req_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_byte_enable = 4'b0000;
        case (i_req_size)
            SZ_BYTE: w_byte_enable = 4'b0001 << i_req_addr[1:0];
            SZ_HALF: w_byte_enable = i_req_addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: w_byte_enable = 4'b1111;
            default: w_byte_enable = 4'b0000;
        endcase
    end

    always_comb begin
        w_store_data = r_wdata;
        case (r_size)
            SZ_BYTE: w_store_data = {4{r_wdata[7:0]}};
            SZ_HALF: w_store_data = {2{r_wdata[15:0]}};
            default: w_store_data = r_wdata;
        endcase
    end

    always_comb begin
        w_lane_byte = i_ram_read_data[7:0];
        case (r_addr[1:0])
            2'd0:    w_lane_byte = i_ram_read_data[7:0];
            2'd1:    w_lane_byte = i_ram_read_data[15:8];
            2'd2:    w_lane_byte = i_ram_read_data[23:16];
            default: w_lane_byte = i_ram_read_data[31:24];
        endcase
        w_lane_half = r_addr[1] ? i_ram_read_data[31:16] : i_ram_read_data[15:0];
    end

    always_comb begin
        w_load_data = i_ram_read_data;
        case (r_size)
            SZ_BYTE: w_load_data = r_unsigned ? {24'd0, w_lane_byte}
                                              : {{24{w_lane_byte[7]}}, w_lane_byte};
            SZ_HALF: w_load_data = r_unsigned ? {16'd0, w_lane_half}
                                              : {{16{w_lane_half[15]}}, w_lane_half};
            default: w_load_data = i_ram_read_data;
        endcase
    end

    // NOTE: every register here updates with <= so all of them see the
    // pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state            <= S_IDLE;
            r_we               <= 1'b0;
            r_size             <= 2'b00;
            r_unsigned         <= 1'b0;
            r_addr             <= '0;
            r_wdata            <= '0;
            r_rsp_valid        <= 1'b0;
            r_rsp_err          <= 1'b0;
            r_rsp_rdata        <= '0;
            r_ram_read_req     <= 1'b0;
            r_ram_write_enable <= 1'b0;
            r_ram_byte_enable  <= 4'b0000;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we       <= i_req_we;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_addr     <= i_req_addr;
                        r_wdata    <= i_req_wdata;
                        if (w_misaligned) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (i_req_we) begin
                            r_state            <= S_WR;
                            r_ram_write_enable <= 1'b1;
                            r_ram_byte_enable  <= w_byte_enable;
                        end else begin
                            r_state        <= S_RD_ISSUE;
                            r_ram_read_req <= 1'b1;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    r_state        <= S_RD_WAIT;
                    r_ram_read_req <= 1'b0;
                end
                S_RD_WAIT: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_we ? '0 : w_load_data;
                end
                S_WR: begin
                    r_state            <= S_RESP;
                    r_rsp_valid        <= 1'b1;
                    r_ram_write_enable <= 1'b0;
                    r_ram_byte_enable  <= 4'b0000;
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                default: begin
                    r_state            <= S_IDLE;
                    r_rsp_valid        <= 1'b0;
                    r_rsp_err          <= 1'b0;
                    r_rsp_rdata        <= '0;
                    r_ram_read_req     <= 1'b0;
                    r_ram_write_enable <= 1'b0;
                    r_ram_byte_enable  <= 4'b0000;
                end
            endcase
        end
    end

    assign o_req_ready        = (r_state == S_IDLE);
    assign o_rsp_valid        = r_rsp_valid;
    assign o_rsp_err          = r_rsp_err;
    assign o_rsp_rdata        = r_rsp_rdata;
    assign o_ram_read_req     = r_ram_read_req;
    assign o_ram_read_addr    = {2'b00, r_addr[ADDR_WIDTH:2]};
    assign o_ram_write_enable = r_ram_write_enable;
    assign o_ram_byte_enable  = r_ram_byte_enable;
    assign o_ram_write_addr   = {2'b00, r_addr[ADDR_WIDTH:2]};
    assign o_ram_write_data   = w_store_data;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, random traffic against
// a byte-array memory model, clock-enable stalls and mid-store reset.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_ram_read_req;
    logic [31:0] o_ram_read_addr;
    logic [31:0] i_ram_read_data;
    logic        o_ram_write_enable;
    logic [3:0]  o_ram_byte_enable;
    logic [31:0] o_ram_write_addr;
    logic [31:0] o_ram_write_data;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
        .clk                (clk),
        .rst                (rst),
        .clk_en             (clk_en),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_we           (i_req_we),
        .i_req_size         (i_req_size),
        .i_req_unsigned     (i_req_unsigned),
        .i_req_addr         (i_req_addr),
        .i_req_wdata        (i_req_wdata),
        .o_rsp_valid        (o_rsp_valid),
        .o_rsp_rdata        (o_rsp_rdata),
        .o_rsp_err          (o_rsp_err),
        .o_ram_read_req     (o_ram_read_req),
        .o_ram_read_addr    (o_ram_read_addr),
        .i_ram_read_data    (i_ram_read_data),
        .o_ram_write_enable (o_ram_write_enable),
        .o_ram_byte_enable  (o_ram_byte_enable),
        .o_ram_write_addr   (o_ram_write_addr),
        .o_ram_write_data   (o_ram_write_data)
    );

    // External RAM: 16 words, byte-lane writes, registered read, gated by clk_en.
    logic [31:0] ram [0:15];
    logic        ram_init;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
            i_ram_read_data <= '0;
        end else if (clk_en) begin
            if (o_ram_write_enable)
                for (int l = 0; l < 4; l++)
                    if (o_ram_byte_enable[l])
                        ram[o_ram_write_addr[3:0]][8*l +: 8] <= o_ram_write_data[8*l +: 8];
            if (o_ram_read_req) i_ram_read_data <= ram[o_ram_read_addr[3:0]];
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        int          lat;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        int          lat;
        int          cycles;
        logic [31:0] rdata;
        logic        err;
        int          n_rd;
        int          n_wr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] wa;
        logic [31:0] ra;
        bit          done;
    } obs_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] ref_mem [0:63];
    vec_t       tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic err, input int lat, input logic [31:0] rdata,
                                input logic [3:0] be, input logic [31:0] wd);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.err = err; v.lat = lat; v.rdata = rdata; v.be = be; v.wd = wd;
        return v;
    endfunction

    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] addr);
        int n;
        n = 1 << sz;
        return (sz == 2'd3) || ((addr % n) != 0);
    endfunction

    // Reference: the access covers 2**size bytes at addr, little-endian.
    task automatic model_predict(input vec_t v, output vec_t e);
        int          n;
        int          be_i;
        logic [63:0] val;
        logic [63:0] m;
        e       = v;
        n       = 1 << v.sz;
        e.err   = is_bad(v.sz, v.addr);
        e.lat   = e.err ? 1 : (v.we ? 2 : 3);
        e.rdata = '0;
        e.be    = '0;
        e.wd    = '0;
        if (!e.err && !v.we) begin
            val = '0;
            for (int i = 0; i < n; i++) val |= 64'(ref_mem[v.addr + i]) << (8 * i);
            m = (64'd1 << (8 * n)) - 64'd1;
            if (!v.uns && val[8*n-1]) val |= ~m;
            e.rdata = val[31:0];
        end
        if (!e.err && v.we) begin
            be_i = ((1 << n) - 1) << (v.addr % 4);
            e.be = be_i[3:0];
            for (int l = 0; l < 4; l++) e.wd[8*l +: 8] = v.wdata[8*(l % n) +: 8];
        end
    endtask

    task automatic model_commit(input vec_t v);
        int n;
        n = 1 << v.sz;
        if (v.we && !is_bad(v.sz, v.addr))
            for (int i = 0; i < n; i++) ref_mem[v.addr + i] = v.wdata[8*i +: 8];
    endtask

    // Issue one request and watch it to completion. Junk is driven on the
    // request port while the access is in flight. Optionally drop clk_en for
    // stall_len cycles once stall_after enabled edges have passed.
    task automatic issue(input vec_t v, input int stall_after, input int stall_len,
                         input logic [4:0] hold_exp, output obs_t ob);
        ob.lat = 0; ob.cycles = 0; ob.rdata = '0; ob.err = 1'b0; ob.n_rd = 0; ob.n_wr = 0;
        ob.be = '0; ob.wd = '0; ob.wa = '0; ob.ra = '0; ob.done = 1'b0;
        @(negedge clk);
        check("ready_idle", 32'(o_req_ready), 32'd1);
        i_req_valid    = 1'b1;
        i_req_we       = v.we;
        i_req_size     = v.sz;
        i_req_unsigned = v.uns;
        i_req_addr     = v.addr;
        i_req_wdata    = v.wdata;
        @(posedge clk);
        for (int k = 0; k < 40 && !ob.done; k++) begin
            @(negedge clk);
            ob.cycles++;
            ob.lat++;
            if (o_ram_read_req) begin
                ob.n_rd++;
                ob.ra = o_ram_read_addr;
            end
            if (o_ram_write_enable) begin
                ob.n_wr++;
                ob.be = o_ram_byte_enable;
                ob.wd = o_ram_write_data;
                ob.wa = o_ram_write_addr;
            end
            if (o_rsp_valid) begin
                ob.done  = 1'b1;
                ob.rdata = o_rsp_rdata;
                ob.err   = o_rsp_err;
                i_req_valid = 1'b0;
                check("rsp_be_clear", 32'(o_ram_byte_enable), 32'd0);
            end else begin
                i_req_valid    = 1'b1;
                i_req_we       = 1'($urandom);
                i_req_size     = 2'($urandom);
                i_req_unsigned = 1'($urandom);
                i_req_addr     = $urandom;
                i_req_wdata    = $urandom;
                if (ob.lat == stall_after) begin
                    clk_en = 1'b0;
                    for (int s = 0; s < stall_len; s++) begin
                        @(negedge clk);
                        ob.cycles++;
                        check("stall_hold",
                              {27'd0, o_req_ready, o_rsp_valid, o_rsp_err, o_ram_read_req, o_ram_write_enable},
                              {27'd0, hold_exp});
                    end
                    clk_en = 1'b1;
                end
            end
        end
        if (!ob.done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_timeout: no o_rsp_valid within 40 cycles, addr 0x%08h", v.addr);
            i_req_valid = 1'b0;
        end
    endtask

    task automatic compare(input string tag, input vec_t e, input obs_t ob);
        bit is_ld;
        bit is_st;
        is_ld = !e.we && !e.err;
        is_st = e.we && !e.err;
        check($sformatf("%s_err", tag), 32'(ob.err), 32'(e.err));
        check($sformatf("%s_lat", tag), 32'(ob.lat), 32'(e.lat));
        check($sformatf("%s_rdata", tag), ob.rdata, e.rdata);
        check($sformatf("%s_nrd", tag), 32'(ob.n_rd), is_ld ? 32'd1 : 32'd0);
        check($sformatf("%s_nwr", tag), 32'(ob.n_wr), is_st ? 32'd1 : 32'd0);
        if (is_st) begin
            check($sformatf("%s_be", tag), 32'(ob.be), 32'(e.be));
            check($sformatf("%s_wdata", tag), ob.wd, e.wd);
            check($sformatf("%s_waddr", tag), ob.wa, e.addr >> 2);
        end
        if (is_ld) check($sformatf("%s_raddr", tag), ob.ra, e.addr >> 2);
    endtask

    task automatic run_model(input string tag, input vec_t v, input int stall_after,
                             input int stall_len, input logic [4:0] hold_exp);
        vec_t e;
        obs_t ob;
        model_predict(v, e);
        issue(v, stall_after, stall_len, hold_exp, ob);
        compare(tag, e, ob);
        if (stall_len > 0)
            check($sformatf("%s_cycles", tag), 32'(ob.cycles), 32'(e.lat + stall_len));
        model_commit(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t ob;
        vec_t v;

        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        rst = 1'b0; clk_en = 1'b1; ram_init = 1'b1;
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'b00; i_req_unsigned = 1'b0;
        i_req_addr = '0; i_req_wdata = '0;

        // Reset state, before any clock edge
        #1;
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_err", 32'(o_rsp_err), 32'd0);
        check("rst_rdata", o_rsp_rdata, 32'd0);
        check("rst_rd", 32'(o_ram_read_req), 32'd0);
        check("rst_wr", 32'(o_ram_write_enable), 32'd0);
        check("rst_be", 32'(o_ram_byte_enable), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ram_init = 1'b0;

        //            we sz uns addr   wdata          err lat rdata          be    wdata-out
        tbl[0]  = mk(1, 2, 0, 'h08, 'hDEADBEEF, 0, 2, 'h0,        'hF, 'hDEADBEEF);
        tbl[1]  = mk(0, 2, 0, 'h08, 'h0,        0, 3, 'hDEADBEEF, 'h0, 'h0);
        tbl[2]  = mk(1, 0, 0, 'h0D, 'h80,       0, 2, 'h0,        'h2, 'h80808080);
        tbl[3]  = mk(0, 0, 0, 'h0D, 'h0,        0, 3, 'hFFFFFF80, 'h0, 'h0);
        tbl[4]  = mk(0, 0, 1, 'h0D, 'h0,        0, 3, 'h00000080, 'h0, 'h0);
        tbl[5]  = mk(1, 2, 0, 'h08, 'h80011234, 0, 2, 'h0,        'hF, 'h80011234);
        tbl[6]  = mk(0, 1, 0, 'h0A, 'h0,        0, 3, 'hFFFF8001, 'h0, 'h0);
        tbl[7]  = mk(0, 2, 0, 'h06, 'h0,        1, 1, 'h0,        'h0, 'h0);
        tbl[8]  = mk(0, 3, 0, 'h00, 'h0,        1, 1, 'h0,        'h0, 'h0);
        tbl[9]  = mk(1, 1, 0, 'h12, 'h1234A5A5, 0, 2, 'h0,        'hC, 'hA5A5A5A5);
        tbl[10] = mk(0, 1, 1, 'h12, 'h0,        0, 3, 'h0000A5A5, 'h0, 'h0);
        tbl[11] = mk(0, 0, 0, 'h13, 'h0,        0, 3, 'hFFFFFFA5, 'h0, 'h0);
        tbl[12] = mk(1, 1, 0, 'h11, 'hFFFF,     1, 1, 'h0,        'h0, 'h0);
        tbl[13] = mk(0, 0, 1, 'h0B, 'h0,        0, 3, 'h00000080, 'h0, 'h0);
        tbl[14] = mk(1, 0, 0, 'h00, 'h7F,       0, 2, 'h0,        'h1, 'h7F7F7F7F);
        tbl[15] = mk(0, 0, 0, 'h00, 'h0,        0, 3, 'h0000007F, 'h0, 'h0);

        for (int i = 0; i < 16; i++) begin
            issue(tbl[i], 0, 0, 5'b0, ob);
            compare($sformatf("vec%0d", i), tbl[i], ob);
            model_commit(tbl[i]);
        end

        // Random traffic against the byte-array model
        for (int i = 0; i < 150; i++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.sz    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            v.uns   = 1'($urandom_range(0, 1));
            v.addr  = 32'($urandom_range(0, 63));
            v.wdata = $urandom;
            run_model($sformatf("rnd%0d", i), v, 0, 0, 5'b0);
        end

        // clk_en low for 5 cycles in RD_WAIT, 3 in RD_ISSUE, 4 in WR
        v = mk(0, 2, 0, 'h08, 'h0, 0, 0, 'h0, 'h0, 'h0);
        run_model("stall_rdwait", v, 2, 5, 5'b00000);
        v = mk(0, 0, 0, 'h0D, 'h0, 0, 0, 'h0, 'h0, 'h0);
        run_model("stall_rdissue", v, 1, 3, 5'b00010);
        v = mk(1, 2, 0, 'h20, 'hCAFEF00D, 0, 0, 'h0, 'h0, 'h0);
        run_model("stall_wr", v, 1, 4, 5'b00001);
        v = mk(0, 2, 0, 'h20, 'h0, 0, 0, 'h0, 'h0, 'h0);
        run_model("stall_wr_rb", v, 0, 0, 5'b0);

        // Reset asserted while the store is in WR
        @(negedge clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd2; i_req_unsigned = 1'b0;
        i_req_addr = 32'h24; i_req_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        check("rst_mid_wr_active", 32'(o_ram_write_enable), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_we_drop", 32'(o_ram_write_enable), 32'd0);
        check("rst_mid_be_drop", 32'(o_ram_byte_enable), 32'd0);
        check("rst_mid_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(o_req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(o_rsp_valid), 32'd0);
        end
        check("rst_ready_after", 32'(o_req_ready), 32'd1);
        v = mk(0, 2, 0, 'h24, 'h0, 0, 0, 'h0, 'h0, 'h0);
        run_model("rst_abandoned_rb", v, 0, 0, 5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
